cycle_controller: RTL

Multi-cycle sequencing controller for the 32-bit, 7-bit-register-index datapath. Latches the opcode/funct of each fetched instruction, steps through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, and drives every datapath control signal plus a one-cycle PC-advance strobe. It stalls on instruction- and data-memory handshakes and abandons data accesses that exceed a watchdog limit. It sits between the instruction/data memories and the datapath's control inputs.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/alu_decoder.sv | 23 ++
 rtl/cycle_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencing controller:
// FSM states, instruction opcodes/functs and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_LW    = 5'd1;
  localparam logic [4:0] OP_SW    = 5'd2;
  localparam logic [4:0] OP_BEQ   = 5'd3;
  localparam logic [4:0] OP_ADDI  = 5'd4;
  localparam logic [4:0] OP_J     = 5'd5;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; flags functs the datapath cannot execute.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluControl,
  output logic       functIllegal
);

  always_comb begin
    aluControl   = ALU_ADD;
    functIllegal = 1'b0;
    case (funct)
      FN_ADD:  aluControl = ALU_ADD;
      FN_SUB:  aluControl = ALU_SUB;
      FN_AND:  aluControl = ALU_AND;
      FN_OR:   aluControl = ALU_OR;
      FN_SLT:  aluControl = ALU_SLT;
      default: functIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cycle_controller.sv
// Multi-cycle instruction sequencer: IR latch, FSM, data-memory watchdog,
// retired-instruction counter and all datapath control decode.
//
// state      | meaning
// FETCH      | wait for instrValid, latch opcode/funct
// DECODE     | static selects valid; J and illegal retire here
// EXECUTE    | ALU cycle; BEQ resolves and retires here
// MEM        | data access held until memReady or watchdog expiry
// WRITEBACK  | register file write, instruction retires
module cycle_controller
  import ctrl_pkg::*;
#(
  parameter int n       = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [n-1:0]     instruction,
  input  logic             instrValid,
  input  logic             memReady,
  input  logic             zero,
  output logic             regDst,
  output logic             aluSrc,
  output logic             memToReg,
  output logic             branch,
  output logic             jump,
  output logic             regWrite,
  output logic             memWrite,
  output logic             memRead,
  output logic             branchMuxSelect,
  output logic [3:0]       aluControl,
  output logic             pcEnable,
  output logic             illegal,
  output logic             busError,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_t          cur_state, nxt_state;
  logic [4:0]      ir_op;
  logic [5:0]      ir_funct;
  logic [WD_W-1:0] wd_cnt;
  logic [3:0]      funct_alu;
  logic            funct_illegal;
  logic            timeout_hit;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^instruction[26:6];

  alu_decoder u_alu_decoder (
    .funct        (ir_funct),
    .aluControl   (funct_alu),
    .functIllegal (funct_illegal)
  );

  logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, ir_illegal, wd_expired;
  assign is_rtype   = (ir_op == OP_RTYPE);
  assign is_lw      = (ir_op == OP_LW);
  assign is_sw      = (ir_op == OP_SW);
  assign is_beq     = (ir_op == OP_BEQ);
  assign is_addi    = (ir_op == OP_ADDI);
  assign is_j       = (ir_op == OP_J);
  assign ir_illegal = (ir_op > OP_J) || (is_rtype && funct_illegal);
  assign wd_expired = (wd_cnt == WD_LIMIT);
  assign state      = cur_state;

  always_comb begin
    nxt_state       = cur_state;
    regDst          = 1'b0;
    aluSrc          = 1'b0;
    memToReg        = 1'b0;
    branch          = 1'b0;
    jump            = 1'b0;
    aluControl      = 4'b0000;
    regWrite        = 1'b0;
    memWrite        = 1'b0;
    memRead         = 1'b0;
    branchMuxSelect = 1'b0;
    pcEnable        = 1'b0;
    illegal         = 1'b0;
    timeout_hit     = 1'b0;

    // IR is stale during FETCH, so the static selects are forced low there
    if (cur_state != S_FETCH) begin
      regDst     = is_rtype;
      aluSrc     = is_lw | is_sw | is_addi;
      memToReg   = is_lw;
      branch     = is_beq;
      jump       = is_j;
      aluControl = is_rtype ? funct_alu : (is_beq ? ALU_SUB : ALU_ADD);
    end

    case (cur_state)
      S_FETCH: begin
        if (instrValid) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        if (ir_illegal || is_j) begin
          illegal   = ir_illegal;
          pcEnable  = 1'b1;
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        branchMuxSelect = is_beq & zero;
        if (is_beq) begin
          pcEnable  = 1'b1;
          nxt_state = S_FETCH;
        end else if (is_lw || is_sw) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_WRITEBACK;
        end
      end
      S_MEM: begin
        // strobes depend only on the watchdog count, never on memReady
        memRead  = is_lw & ~wd_expired;
        memWrite = is_sw & ~wd_expired;
        if (memReady || wd_expired) begin
          timeout_hit = wd_expired & ~memReady;
          if (is_sw) begin
            pcEnable  = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        regWrite  = 1'b1;
        pcEnable  = 1'b1;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_FETCH;
      ir_op     <= '0;
      ir_funct  <= '0;
      wd_cnt    <= '0;
      retired   <= '0;
      busError  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_FETCH && instrValid) begin
        ir_op    <= instruction[31:27];
        ir_funct <= instruction[5:0];
      end
      if (cur_state != S_MEM) wd_cnt <= '0;
      else if (!memReady && !wd_expired) wd_cnt <= wd_cnt + WD_W'(1);
      if (pcEnable) retired <= retired + CNT_W'(1);
      if (timeout_hit) busError <= 1'b1;
    end
  end

endmodule
